// File: rtl/spart.sv
`default_nettype none
// ============================================================================
// spart : memory-mapped 8N1 UART slave with a TX register, an RX FIFO and a
//         status register. Bus requests that cannot complete are stalled.
// Revision: 1.0
// ============================================================================
module spart #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000001C,
    parameter int          BAUD_DIV   = 434,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_i,
    input  logic        read_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    input  logic        rxd,
    output logic        txd
);

    localparam int            CW        = $clog2(BAUD_DIV);
    localparam int            AW        = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [AW:0]   DEPTH_V   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- bus decode ----------------
    logic sel_tx, sel_rx, sel_st, do_wr, do_rd;
    assign sel_tx = (addr_i == BASE_ADDR);
    assign sel_rx = (addr_i == BASE_ADDR + 32'd1);
    assign sel_st = (addr_i == BASE_ADDR + 32'd2);
    assign do_wr  = write_i;
    assign do_rd  = read_i & ~write_i;

    logic unused_data_bits;
    assign unused_data_bits = |data_i[31:8];

    // ---------------- transmitter ----------------
    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          txd_q, txd_n;
    logic          tx_busy, tx_load;

    assign tx_busy = (tx_state != TX_IDLE);
    assign tx_load = do_wr & sel_tx & ~tx_busy & ~rst;
    assign txd     = txd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd_q    <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            txd_q    <= txd_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        case (tx_state)
            TX_IDLE: begin
                if (tx_load) begin
                    tx_state_n = TX_START;
                    tx_cnt_n   = '0;
                    tx_shift_n = data_i[7:0];
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                end else begin
                    tx_cnt_n = tx_cnt + CW'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) tx_state_n = TX_STOP;
                    else                tx_bit_n   = tx_bit + 3'd1;
                end else begin
                    tx_cnt_n = tx_cnt + CW'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = TX_IDLE;
                    tx_cnt_n   = '0;
                end else begin
                    tx_cnt_n = tx_cnt + CW'(1);
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        // txd is registered from the next state so the line never glitches
        case (tx_state_n)
            TX_START: txd_n = 1'b0;
            TX_DATA:  txd_n = tx_shift_n[0];
            default:  txd_n = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    logic          sync1, sync2, rx_prev;
    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_push, rx_ferr_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            sync1    <= rxd;
            sync2    <= sync1;
            rx_prev  <= sync2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        rx_push     = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev & ~sync2) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = sync2 ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {sync2, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n    = '0;
                    rx_state_n  = RX_IDLE;
                    rx_push     = sync2;
                    rx_ferr_set = ~sync2;
                end else begin
                    rx_cnt_n = rx_cnt + CW'(1);
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ---------------- RX FIFO and sticky flags ----------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic        rx_full, rx_avail, pop, push_ok, overrun_set, stat_rd;
    logic        overrun, ferr;

    assign count       = wr_ptr - rd_ptr;
    assign rx_full     = (count == DEPTH_V);
    assign rx_avail    = (count != '0);
    assign pop         = do_rd & sel_rx & rx_avail;
    // a pop on the same edge frees the slot the push needs
    assign push_ok     = rx_push & (~rx_full | pop);
    assign overrun_set = rx_push & rx_full & ~pop;
    assign stat_rd     = do_rd & sel_st;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            if (overrun_set)  overrun <= 1'b1;
            else if (stat_rd) overrun <= 1'b0;
            if (rx_ferr_set)  ferr <= 1'b1;
            else if (stat_rd) ferr <= 1'b0;
        end
    end

    // ---------------- bus response ----------------
    always_comb begin
        ack_o  = 1'b0;
        data_o = '0;
        if (!rst) begin
            if (do_wr) begin
                if (sel_tx)               ack_o = ~tx_busy;
                else if (sel_rx | sel_st) ack_o = 1'b1;
            end else if (do_rd) begin
                if (sel_tx) begin
                    ack_o = 1'b1;
                end else if (sel_rx) begin
                    ack_o = rx_avail;
                    if (rx_avail) data_o = {24'b0, mem[rd_ptr[AW-1:0]]};
                end else if (sel_st) begin
                    ack_o  = 1'b1;
                    data_o = {27'b0, ferr, overrun, rx_full, rx_avail, tx_busy};
                end
            end
        end
    end

endmodule
`default_nettype wire
